and_reduce_sequencer: RTL and testbench

- Time-multiplexed controller for the 8-operand reduction-AND datapath. It accepts one job of eight WIDTH-bit operands (a..h) through a valid/ready handshake.
- It feeds Port_Num operands per cycle through one shared Port_Num-wide reduction-AND slice and accumulates a 1-bit result.
- The result is presented on q through an output valid/ready handshake.
- It sits wherever the full parallel reduction is too wide, trading area for latency.

---
 rtl/and_reduce_sequencer_if.sv | 23 ++
 rtl/and_reduce_sequencer.sv | 102 ++++++++++
 tb/tb_and_reduce_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/and_reduce_sequencer_if.sv
// Job/result handshake bundle for and_reduce_sequencer: operand input side,
// result output side and busy status.
interface and_reduce_sequencer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b, c, d, e, f, g, h;
    logic [WIDTH-1:0] q;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    modport master (
        output in_valid, a, b, c, d, e, f, g, h, out_ready,
        input  in_ready, q, out_valid, busy
    );

    modport slave (
        input  in_valid, a, b, c, d, e, f, g, h, out_ready,
        output in_ready, q, out_valid, busy
    );
endinterface

// File: rtl/and_reduce_sequencer.sv
// Time-multiplexed 8-operand reduction AND: Port_Num operands per RUN cycle
// through one shared slice, 1-bit result zero-extended onto q.
module and_reduce_sequencer #(
    parameter int unsigned Port_Num   = 2,
    parameter int unsigned WIDTH      = 8,
    parameter bit          EARLY_EXIT = 1'b0
) (
    input logic                  clk,
    input logic                  rst_n,
    and_reduce_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op [8];
    logic [3:0]       idx;
    logic             acc;
    logic             slice;
    logic             res;
    logic [31:0]      idx_w;
    logic             last;

    assign idx_w = 32'(idx);
    assign last  = (idx_w + Port_Num) >= 32'd8;
    assign res   = acc & slice;

    // Indices past 7 never match, so they behave as all-ones operands.
    always_comb begin
        slice = 1'b1;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i >= idx_w && i < idx_w + Port_Num) begin
                slice = slice & (&op[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            acc           <= 1'b1;
            bus.q         <= '0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.in_ready  <= 1'b1;
            for (int unsigned i = 0; i < 8; i++) begin
                op[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op[0]        <= bus.a;
                        op[1]        <= bus.b;
                        op[2]        <= bus.c;
                        op[3]        <= bus.d;
                        op[4]        <= bus.e;
                        op[5]        <= bus.f;
                        op[6]        <= bus.g;
                        op[7]        <= bus.h;
                        acc          <= 1'b1;
                        idx          <= '0;
                        state        <= RUN;
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b1;
                    end
                end
                RUN: begin
                    acc <= res;
                    idx <= idx + 4'(Port_Num);
                    if (last) begin
                        state         <= DONE;
                        bus.q         <= WIDTH'(res);
                        bus.out_valid <= 1'b1;
                        bus.busy      <= 1'b0;
                    end else if (EARLY_EXIT && !res) begin
                        state         <= DONE;
                        bus.q         <= '0;
                        bus.out_valid <= 1'b1;
                        bus.busy      <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.q         <= '0;
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    bus.in_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_and_reduce_sequencer.sv
// Drives four sequencer configurations in lockstep (P=2, P=2 early-exit,
// P=3, P=8; WIDTH=7) and checks latency, result and handshake behaviour.
module tb_and_reduce_sequencer;
    localparam int unsigned W  = 7;
    localparam int unsigned ND = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          out_ready;
    logic [W-1:0]  opv [8];
    logic [ND-1:0] ov;
    logic [ND-1:0] rdy;
    logic [ND-1:0] bsy;
    logic [W-1:0]  qv [ND];

    int checks;
    int failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < ND; k++) begin : g_dut
        localparam int unsigned PN = (k == 2) ? 3 : (k == 3) ? 8 : 2;
        localparam bit          EE = (k == 1);

        and_reduce_sequencer_if #(.WIDTH(W)) bus ();

        assign bus.in_valid  = in_valid;
        assign bus.out_ready = out_ready;
        assign bus.a = opv[0];
        assign bus.b = opv[1];
        assign bus.c = opv[2];
        assign bus.d = opv[3];
        assign bus.e = opv[4];
        assign bus.f = opv[5];
        assign bus.g = opv[6];
        assign bus.h = opv[7];
        assign ov[k]  = bus.out_valid;
        assign rdy[k] = bus.in_ready;
        assign bsy[k] = bus.busy;
        assign qv[k]  = bus.q;

        and_reduce_sequencer #(
            .Port_Num  (PN),
            .WIDTH     (W),
            .EARLY_EXIT(EE)
        ) dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus)
        );
    end

    typedef struct {
        logic [W-1:0] op [8];
        logic [W-1:0] exp_q;
        int           lat [ND];
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d: got %0h expected %0h", name, k, act, exp);
        end
    endtask

    // Apply vector vi, measure per-DUT latency, hold backpressure, then release.
    task automatic run_job(input int vi, input int hold);
        int lat [ND];
        for (int k = 0; k < ND; k++) lat[k] = 0;
        for (int i = 0; i < 8; i++) opv[i] = tbl[vi].op[i];
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) opv[i] = '0;
        for (int k = 0; k < ND; k++) begin
            chk("in_ready_after_accept", k, 32'(rdy[k]), 32'd0);
            chk("busy_after_accept", k, 32'(bsy[k]), 32'd1);
        end
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < ND; k++) begin
                if (ov[k] && lat[k] == 0) lat[k] = n;
            end
            if (&ov) break;
        end
        for (int k = 0; k < ND; k++) begin
            chk("latency", k, 32'(lat[k]), 32'(tbl[vi].lat[k]));
            chk("q_result", k, 32'(qv[k]), 32'(tbl[vi].exp_q));
            chk("busy_done", k, 32'(bsy[k]), 32'd0);
        end
        repeat (hold) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < ND; k++) begin
                chk("hold_out_valid", k, 32'(ov[k]), 32'd1);
                chk("hold_q", k, 32'(qv[k]), 32'(tbl[vi].exp_q));
                chk("hold_in_ready", k, 32'(rdy[k]), 32'd0);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < ND; k++) begin
            chk("release_out_valid", k, 32'(ov[k]), 32'd0);
            chk("release_in_ready", k, 32'(rdy[k]), 32'd1);
            chk("release_q", k, 32'(qv[k]), 32'd0);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) opv[i] = '0;

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 8; i++) tbl[v].op[i] = 7'h7F;
            tbl[v].exp_q = 7'h00;
        end
        tbl[0].exp_q = 7'h01;
        tbl[0].lat = '{4, 4, 3, 1};
        tbl[1].op[3] = 7'h7E;
        tbl[1].lat = '{4, 2, 3, 1};
        tbl[2].op[0] = 7'h7E;
        tbl[2].lat = '{4, 1, 3, 1};
        tbl[3].op[7] = 7'h3F;
        tbl[3].lat = '{4, 4, 3, 1};
        for (int i = 0; i < 8; i++) tbl[4].op[i] = 7'h00;
        tbl[4].lat = '{4, 1, 3, 1};
        tbl[5].op[4] = 7'h7D;
        tbl[5].lat = '{4, 3, 3, 1};

        rst_n = 1'b0;
        #12;
        for (int k = 0; k < ND; k++) begin
            chk("reset_in_ready", k, 32'(rdy[k]), 32'd1);
            chk("reset_out_valid", k, 32'(ov[k]), 32'd0);
            chk("reset_busy", k, 32'(bsy[k]), 32'd0);
            chk("reset_q", k, 32'(qv[k]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++) run_job(v, 0);

        run_job(0, 5);

        // in_valid held high through DONE: no accept on the handshake edge.
        for (int i = 0; i < 8; i++) opv[i] = 7'h7F;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < ND; k++) chk("held_done", k, 32'(ov[k]), 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < ND; k++) begin
            chk("held_idle_ready", k, 32'(rdy[k]), 32'd1);
            chk("held_idle_busy", k, 32'(bsy[k]), 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 0; k < ND; k++) chk("held_second_accept", k, 32'(bsy[k]), 32'd1);
        out_ready = 1'b1;
        for (int n = 0; n < 12 && rdy != '1; n++) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        for (int k = 0; k < ND; k++) chk("held_drain", k, 32'(rdy[k]), 32'd1);

        // Asynchronous reset during the second RUN cycle aborts the job.
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 0, 32'(ov[0]), 32'd0);
        chk("abort_q", 0, 32'(qv[0]), 32'd0);
        chk("abort_in_ready", 0, 32'(rdy[0]), 32'd1);
        chk("abort_busy", 0, 32'(bsy[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_stays_idle", 0, 32'(ov[0]), 32'd0);
        run_job(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
